// File: rtl/alu_pkg.sv
// Shared opcode constants and instruction-word field slicing for the ALU issue path.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b010010;

    // The 16-bit immediate overlays rd/shamt/funct, so it is sliced separately.
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [31:0] word);
        return instr_fields_t'(word);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue bus between the decode/issue stage (master) and the ALU (slave).
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs_content;
    logic [DATA_W-1:0] rt_content;
    logic [4:0]        shamt;
    logic [5:0]        ALU_control;
    logic [15:0]       immediate;
    logic [ADDR_W-1:0] dest_addr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output opcode, rs_content, rt_content, shamt, ALU_control, immediate,
               dest_addr, out_valid,
        input  out_ready
    );

    modport slave (
        input  opcode, rs_content, rt_content, shamt, ALU_control, immediate,
               dest_addr, out_valid,
        output out_ready
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port. r0 always reads zero and ignores writes.
module regfile_2r1w #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Writeback port; reset clears the whole array in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes the instruction word, reads operands (with
// writeback bypass), stalls on scoreboard hazards and drives a one-entry
// output register toward the ALU.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    alu_issue_stage_if.master issue
);

    instr_fields_t     f;
    logic              branch;
    logic              rt_used;
    logic [ADDR_W-1:0] rs_a;
    logic [ADDR_W-1:0] rt_a;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] rf_rs;
    logic [DATA_W-1:0] rf_rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] busy_nxt;
    logic              hazard;
    logic              free;
    logic              accept;

    assign f       = split_instr(instr);
    assign branch  = is_branch(f.op);
    assign rt_used = (f.op == OP_RTYPE) || branch;
    assign rs_a    = ADDR_W'(f.rs);
    assign rt_a    = ADDR_W'(f.rt);

    // Destination decode: R-type writes rd, branches write nothing, others write rt.
    always_comb begin
        dest = rt_a;
        if (f.op == OP_RTYPE) begin
            dest = ADDR_W'(f.rd);
        end else if (branch) begin
            dest = '0;
        end
    end

    regfile_2r1w #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs_a),
        .rd_data_a (rf_rs),
        .rd_addr_b (rt_a),
        .rd_data_b (rf_rt),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // A writeback landing this cycle is forwarded so a waiting consumer can issue now.
    assign rs_val = (wb_en && (wb_addr == rs_a) && (rs_a != '0)) ? wb_data : rf_rs;
    assign rt_val = (wb_en && (wb_addr == rt_a) && (rt_a != '0)) ? wb_data : rf_rt;

    // A register being written back this cycle no longer blocks issue.
    always_comb begin
        busy_eff = busy;
        if (wb_en) begin
            busy_eff[wb_addr] = 1'b0;
        end
    end

    // Stalling on a busy destination resolves WAW, so one busy bit per register is enough.
    assign hazard      = busy_eff[rs_a] | (rt_used & busy_eff[rt_a]) | busy_eff[dest];
    assign free        = ~issue.out_valid | issue.out_ready | flush;
    assign instr_ready = free & ~hazard & ~rst;
    assign accept      = instr_valid & instr_ready;

    // Scoreboard update: clears first, so a same-cycle issue to the register wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_en && (wb_addr != '0)) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (flush && issue.out_valid && (issue.dest_addr != '0)) begin
            busy_nxt[issue.dest_addr] = 1'b0;
        end
        if (accept && (dest != '0)) begin
            busy_nxt[dest] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Output register: load on accept, drain when free, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue.out_valid   <= 1'b0;
            issue.opcode      <= '0;
            issue.rs_content  <= '0;
            issue.rt_content  <= '0;
            issue.shamt       <= '0;
            issue.ALU_control <= '0;
            issue.immediate   <= '0;
            issue.dest_addr   <= '0;
        end else if (accept) begin
            issue.out_valid   <= 1'b1;
            issue.opcode      <= f.op;
            issue.rs_content  <= rs_val;
            issue.rt_content  <= rt_val;
            issue.shamt       <= f.shamt;
            issue.ALU_control <= (f.op == OP_RTYPE) ? f.funct : 6'b0;
            issue.immediate   <= instr[15:0];
            issue.dest_addr   <= dest;
        end else if (free) begin
            issue.out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a behavioural model of the issue stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;

    alu_issue_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    alu_issue_stage #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .issue       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit last_ready;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ov;
    logic [5:0]  m_op;
    logic [31:0] m_rs;
    logic [31:0] m_rt;
    logic [4:0]  m_sh;
    logic [5:0]  m_ctl;
    logic [15:0] m_imm;
    logic [4:0]  m_dest;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] lo);
        return {op, rs, rt, lo};
    endfunction

    function automatic bit blocked(input int r, input bit we, input logic [4:0] wa);
        return m_busy[r] && !(we && (int'(wa) == r));
    endfunction

    function automatic logic [31:0] operand(input int r, input bit we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && (int'(wa) == r)) return wd;
        return m_regs[r];
    endfunction

    // One clock: drive inputs, check instr_ready, advance model, check outputs.
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit we,
                        input logic [4:0] wa, input logic [31:0] wd, input bit fl, input bit r);
        logic [5:0] op;
        int  rs, rt, rd, dest;
        bit  br, rt_src, hz, fr, rdy;
        @(negedge clk);
        instr = ins; instr_valid = v; bus.out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd; flush = fl; rst = r;
        op = ins[31:26];
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        br = (op == 6'b000100) || (op == 6'b000101);
        rt_src = (op == 6'd0) || br;
        dest = (op == 6'd0) ? rd : (br ? 0 : rt);
        hz  = blocked(rs, we, wa) || (rt_src && blocked(rt, we, wa)) || blocked(dest, we, wa);
        fr  = !m_ov || ordy || fl;
        rdy = fr && !hz && !r;
        #1;
        check("instr_ready", instr_ready, rdy);
        last_ready = instr_ready;
        if (r) begin
            m_ov = 0; m_op = 0; m_rs = 0; m_rt = 0; m_sh = 0; m_ctl = 0; m_imm = 0; m_dest = 0;
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 0;
                m_regs[i] = 0;
            end
        end else begin
            if (we && wa != 0) m_busy[wa] = 0;
            if (fl && m_ov && m_dest != 0) m_busy[m_dest] = 0;
            if (v && rdy) begin
                if (dest != 0) m_busy[dest] = 1;
                m_ov   = 1;
                m_op   = op;
                m_rs   = operand(rs, we, wa, wd);
                m_rt   = operand(rt, we, wa, wd);
                m_sh   = ins[10:6];
                m_ctl  = (op == 6'd0) ? ins[5:0] : 6'd0;
                m_imm  = ins[15:0];
                m_dest = 5'(dest);
            end else if (fr) begin
                m_ov = 0;
            end
            if (we && wa != 0) m_regs[wa] = wd;
        end
        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, m_ov);
        check("opcode", bus.opcode, m_op);
        check("rs_content", bus.rs_content, m_rs);
        check("rt_content", bus.rt_content, m_rt);
        check("shamt", bus.shamt, m_sh);
        check("ALU_control", bus.ALU_control, m_ctl);
        check("immediate", bus.immediate, m_imm);
        check("dest_addr", bus.dest_addr, m_dest);
    endtask

    initial begin
        logic [31:0] held_rs;
        logic [4:0]  held_dest;
        logic [31:0] ins;
        logic [5:0]  op;

        rst = 1'b1; instr = '0; instr_valid = 1'b0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; flush = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
        m_ov = 0; m_op = 0; m_rs = 0; m_rt = 0; m_sh = 0; m_ctl = 0; m_imm = 0; m_dest = 0;

        // Reset
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_dest", bus.dest_addr, 0);

        // Writeback r1=15, then ADDI r2 = r1 + 19
        step(0, 0, 1, 1, 5'd1, 32'd15, 0, 0);
        step(1, mk(6'b010010, 5'd1, 5'd2, 16'd19), 1, 0, 0, 0, 0, 0);
        check("addi_opcode", bus.opcode, 32'h12);
        check("addi_rs", bus.rs_content, 32'd15);
        check("addi_imm", bus.immediate, 32'd19);
        check("addi_dest", bus.dest_addr, 32'd2);
        check("addi_valid", bus.out_valid, 1);

        // RAW on r2: stall until writeback r2=23 arrives, then bypass
        ins = mk(6'd0, 5'd2, 5'd0, {5'd4, 5'd0, 6'h20});
        step(1, ins, 1, 0, 0, 0, 0, 0);
        check("raw_stall0", last_ready, 0);
        step(1, ins, 1, 0, 0, 0, 0, 0);
        check("raw_stall1", last_ready, 0);
        step(1, ins, 1, 1, 5'd2, 32'd23, 0, 0);
        check("raw_release", last_ready, 1);
        check("raw_bypass", bus.rs_content, 32'd23);

        // Backpressure for 3 cycles
        held_rs = bus.rs_content;
        held_dest = bus.dest_addr;
        ins = mk(6'b010010, 5'd0, 5'd6, 16'd7);
        for (int k = 0; k < 3; k++) begin
            step(1, ins, 0, 0, 0, 0, 0, 0);
            check("hold_ready", last_ready, 0);
            check("hold_rs", bus.rs_content, held_rs);
            check("hold_dest", bus.dest_addr, held_dest);
        end
        step(1, ins, 1, 0, 0, 0, 0, 0);
        check("hold_release", bus.dest_addr, 32'd6);

        // R-type field decode, then branch with no destination
        step(1, mk(6'd0, 5'd0, 5'd0, {5'd3, 5'd4, 6'b100000}), 1, 0, 0, 0, 0, 0);
        check("rtype_ctl", bus.ALU_control, 32'h20);
        check("rtype_shamt", bus.shamt, 32'd4);
        check("rtype_dest", bus.dest_addr, 32'd3);
        step(1, mk(6'b000100, 5'd0, 5'd0, 16'h0010), 1, 0, 0, 0, 0, 0);
        check("beq_dest", bus.dest_addr, 32'd0);
        check("beq_ctl", bus.ALU_control, 32'd0);

        // Flush an instruction targeting r5, then consume r5 immediately
        step(1, mk(6'b010010, 5'd0, 5'd5, 16'd1), 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("flush_valid", bus.out_valid, 0);
        step(1, mk(6'd0, 5'd5, 5'd5, {5'd7, 5'd0, 6'h20}), 1, 0, 0, 0, 0, 0);
        check("flush_r5_free", last_ready, 1);

        // Reset mid-operation with busy registers outstanding
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_op", bus.opcode, 0);
        check("rst_mid_rs", bus.rs_content, 0);
        step(1, mk(6'd0, 5'd3, 5'd4, {5'd6, 5'd0, 6'h22}), 1, 0, 0, 0, 0, 0);
        check("rst_mid_ready", last_ready, 1);

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 4))
                0: op = 6'b000000;
                1: op = 6'b000100;
                2: op = 6'b000101;
                3: op = 6'b010010;
                default: op = 6'($urandom_range(0, 63));
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
